// File: rtl/fetch_seq.sv
// fetch_seq: assembles 32-bit instruction words from a byte-wide, combinational-read ROM.
// Latency: four FETCH edges per word (big-endian byte order), one HOLD cycle minimum -> 5 cycles/instr.
// Backpressure: stall freezes the held word in HOLD; stall is ignored while bytes are being fetched.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   stall        consumer not ready; held instruction is not consumed
//   redirect     branch/jump/flush, highest priority at the sampling edge
//   redirect_pc  new fetch address (low two bits ignored)
//   rom_addr     byte address presented to the instruction ROM
//   rom_data     byte returned for rom_addr in the same cycle
//   instr        assembled instruction word
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc may be consumed
//   fetch_count  instructions consumed since reset (wraps)

module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        consume;

  // Only the word-aligned part of a redirect target matters.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign consume = (state_q == S_HOLD) && instr_valid_q && !stall;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      cnt_q         <= 2'd0;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Redirect wins over byte capture, completion and consumption alike.
      // The byte on rom_data this cycle is not captured; instr keeps whatever
      // it held, which is harmless because instr_valid drops.
      pc_d          = {redirect_pc[31:2], 2'b00};
      cnt_d         = 2'd0;
      state_d       = S_FETCH;
      instr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          // Lowest address lands in the most significant byte.
          unique case (cnt_q)
            2'd0: instr_d[31:24] = rom_data;
            2'd1: instr_d[23:16] = rom_data;
            2'd2: instr_d[15:8]  = rom_data;
            2'd3: instr_d[7:0]   = rom_data;
            default: instr_d = instr_q;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d       = S_HOLD;
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
          end
        end
        S_HOLD: begin
          if (consume) begin
            pc_d          = pc_q + 32'd4;
            cnt_d         = 2'd0;
            state_d       = S_FETCH;
            instr_valid_d = 1'b0;
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // cnt only ever replaces the two low address bits, so no carry reaches pc.
  // During reset the registers already hold RESET_PC / cnt=0, which makes
  // rom_addr follow reset immediately without an extra mux.
  always_comb begin
    rom_addr = {pc_q[31:2], 2'b00};
    if (state_q == S_FETCH) begin
      rom_addr = {pc_q[31:2], cnt_q};
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic        clk;
  logic        rst, rst2;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr, rom_addr2;
  logic [7:0]  rom_data, rom_data2;
  logic [31:0] instr, instr_pc, fetch_count;
  logic [31:0] instr2, instr_pc2, fetch_count2;
  logic        instr_valid, instr_valid2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  fetch_seq u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_count(fetch_count)
  );

  fetch_seq #(.RESET_PC(32'hFFFFFFFC)) u_dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .fetch_count(fetch_count2)
  );

  // ROM contents: fixed words at the addresses the test visits.
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'hBFC00000: b = 8'h13;
      32'hBFC00001: b = 8'h05;
      32'hBFC00002: b = 8'hA0;
      32'hBFC00003: b = 8'h00;
      32'hBFC00004: b = 8'h24;
      32'hBFC00005: b = 8'h08;
      32'hBFC00006: b = 8'h00;
      32'hBFC00007: b = 8'h01;
      32'hBFC00040: b = 8'hCA;
      32'hBFC00041: b = 8'hFE;
      32'hBFC00042: b = 8'hF0;
      32'hBFC00043: b = 8'h0D;
      32'hBFC00104: b = 8'hDE;
      32'hBFC00105: b = 8'hAD;
      32'hBFC00106: b = 8'hBE;
      32'hBFC00107: b = 8'hEF;
      32'hFFFFFFFC: b = 8'h11;
      32'hFFFFFFFD: b = 8'h22;
      32'hFFFFFFFE: b = 8'h33;
      32'hFFFFFFFF: b = 8'h44;
      32'h00000000: b = 8'h55;
      32'h00000001: b = 8'h66;
      32'h00000002: b = 8'h77;
      32'h00000003: b = 8'h88;
      default:      b = a[7:0] ^ 8'h3C;
    endcase
    return b;
  endfunction

  always_comb rom_data  = rom_byte(rom_addr);
  always_comb rom_data2 = rom_byte(rom_addr2);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    sb.push_back(e);
  endtask

  // Monitor: each new presentation of a valid instruction is scored against
  // the oldest outstanding expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (instr_valid && !prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_instr: got pc %h instr %h with no expectation", instr_pc, instr);
        end else begin
          e = sb.pop_front();
          chk("mon_instr", instr, e.ins);
          chk("mon_instr_pc", instr_pc, e.pc);
        end
      end
      prev = instr_valid;
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();

    // Reset state
    chk("rst_rom_addr", rom_addr, 32'hBFC00000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'hBFC00000);
    chk("rst_instr", instr, 32'd0);
    chk("rst2_rom_addr", rom_addr2, 32'hFFFFFFFC);

    // First fetch from reset vector; both instances start together
    rst = 1'b0; rst2 = 1'b0;
    push(32'hBFC00000, 32'h1305A000);
    chk("f0_rom_addr", rom_addr, 32'hBFC00000);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("f0_rom_addr", rom_addr, 32'hBFC00000 + i);
      chk("f0_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    tick();
    chk("f0_valid", {31'd0, instr_valid}, 32'd1);
    chk("f0_hold_addr", rom_addr, 32'hBFC00000);
    chk("wrap_valid", {31'd0, instr_valid2}, 32'd1);
    chk("wrap_instr_pc", instr_pc2, 32'hFFFFFFFC);
    chk("wrap_instr", instr2, 32'h11223344);

    // Stall in HOLD for 6 cycles
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h1305A000);
      chk("stall_instr_pc", instr_pc, 32'hBFC00000);
      chk("stall_rom_addr", rom_addr, 32'hBFC00000);
      chk("stall_count", fetch_count, 32'd0);
      if (i < 4) chk("wrap_rom_addr", rom_addr2, i);
      if (i == 0) chk("wrap_count", fetch_count2, 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("cons_valid", {31'd0, instr_valid}, 32'd0);
    chk("cons_count", fetch_count, 32'd1);
    chk("cons_rom_addr", rom_addr, 32'hBFC00004);

    // Second sequential word, then redirect on the consuming edge
    push(32'hBFC00004, 32'h24080001);
    repeat (4) tick();
    chk("f1_valid", {31'd0, instr_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'hBFC00040;
    tick();
    redirect = 1'b0;
    chk("rdc_count", fetch_count, 32'd1);
    chk("rdc_valid", {31'd0, instr_valid}, 32'd0);
    chk("rdc_rom_addr", rom_addr, 32'hBFC00040);
    push(32'hBFC00040, 32'hCAFEF00D);
    repeat (4) tick();
    chk("rdc_valid2", {31'd0, instr_valid}, 32'd1);
    chk("rdc_count2", fetch_count, 32'd1);

    // Consume, then redirect mid-word (cnt=2) to an unaligned target
    tick();
    chk("c2_count", fetch_count, 32'd2);
    chk("c2_rom_addr", rom_addr, 32'hBFC00044);
    repeat (2) tick();
    chk("mid_rom_addr", rom_addr, 32'hBFC00046);
    redirect = 1'b1; redirect_pc = 32'hBFC00107;
    tick();
    redirect = 1'b0;
    chk("rdm_rom_addr", rom_addr, 32'hBFC00104);
    chk("rdm_valid", {31'd0, instr_valid}, 32'd0);
    push(32'hBFC00104, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdm_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    tick();
    chk("rdm_valid_hi", {31'd0, instr_valid}, 32'd1);

    // Consume, then redirect on the edge that would complete a word (cnt=3)
    tick();
    chk("c3_count", fetch_count, 32'd3);
    chk("c3_rom_addr", rom_addr, 32'hBFC00108);
    repeat (3) tick();
    chk("cnt3_rom_addr", rom_addr, 32'hBFC0010B);
    redirect = 1'b1; redirect_pc = 32'hBFC00042;
    tick();
    redirect = 1'b0;
    chk("rd3_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd3_rom_addr", rom_addr, 32'hBFC00040);
    chk("rd3_count", fetch_count, 32'd3);
    push(32'hBFC00040, 32'hCAFEF00D);
    repeat (4) tick();
    chk("rd3_valid_hi", {31'd0, instr_valid}, 32'd1);

    // Asynchronous reset pulse while holding a word, no clock edge inside it
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_rom_addr", rom_addr, 32'hBFC00000);
    chk("arst_count", fetch_count, 32'd0);
    #1 rst = 1'b0;
    push(32'hBFC00000, 32'h1305A000);
    repeat (4) tick();
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    chk("post_rst_count", fetch_count, 32'd1);
    chk("post_rst_rom_addr", rom_addr, 32'hBFC00004);

    repeat (2) tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, first fetch address after reset (bits [1:0] must be 00).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  downstream not ready; held instruction is not consumed.
REQ-005 SHALL have port redirect  input  1  branch/jump/flush request, sampled on clk.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address when redirect=1.
REQ-007 SHALL have port rom_addr  output  32  byte address to byte-wide instruction ROM (combinational read).
REQ-008 SHALL have port rom_data  input  8  byte returned for rom_addr in the same cycle.
REQ-009 SHALL have port instr  output  32  assembled instruction word.
REQ-010 SHALL have port instr_pc  output  32  address of instr.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc valid for consumption.
REQ-012 SHALL have port fetch_count  output  32  number of instructions consumed since reset.

Function
REQ-013 SHALL implement two states: FETCH (byte counter cnt 0..3) and HOLD.
REQ-014 SHALL drive rom_addr = {pc[31:2], cnt[1:0]} in FETCH and {pc[31:2], 2'b00} in HOLD; no carry into pc from cnt.
REQ-015 SHALL capture rom_data in FETCH at each edge: cnt=0 -> instr[31:24], cnt=1 -> [23:16], cnt=2 -> [15:8], cnt=3 -> [7:0] (lowest address in MSB).
REQ-016 SHALL increment cnt each FETCH cycle; on the edge with cnt=3 SHALL enter HOLD, set instr_valid=1, instr_pc=pc.
REQ-017 SHALL hold instr, instr_pc, instr_valid stable in HOLD while stall=1.
REQ-018 Consumption = HOLD && instr_valid && !stall; at that edge SHALL set pc=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0), cnt=0, instr_valid=0, state FETCH, fetch_count+1 (wraps at 2^32).
REQ-019 Latency: first instr_valid asserted 4 edges after entering FETCH; minimum 5 cycles per instruction.
REQ-020 stall SHALL have no effect in FETCH; byte sequencing continues.
REQ-021 redirect=1 SHALL take priority over all other events at that edge: pc={redirect_pc[31:2],2'b00}, cnt=0, state FETCH, instr_valid=0, partially assembled bytes discarded.
REQ-022 redirect coincident with consumption SHALL NOT increment fetch_count; held instruction is dropped.
REQ-023 redirect coincident with cnt=3 SHALL NOT assert instr_valid.
REQ-024 redirect_pc[1:0] SHALL be ignored (forced 00).
REQ-025 instr SHALL retain last assembled value when instr_valid=0 (bytes overwrite in place); consumers use instr_valid only.

Reset
REQ-026 On rst=1, asynchronously: state FETCH, cnt=0, pc=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0, fetch_count=0.
REQ-027 While rst=1, rom_addr SHALL equal RESET_PC.
REQ-028 rst asserted mid-FETCH or in HOLD SHALL abandon the operation; first fetch after release starts at RESET_PC, cnt=0.
REQ-029 After rst deasserts, first capture SHALL occur at the first rising edge.

Verification
REQ-030 Reset release, ROM bytes at 0xBFC00000..3 = 13,05,A0,00, stall=0 -> rom_addr 0xBFC00000..3 over 4 cycles; instr=0x1305A000, instr_pc=0xBFC00000, instr_valid=1 on cycle 5; next fetch at 0xBFC00004, fetch_count=1.
REQ-031 stall=1 for 6 cycles while in HOLD -> instr/instr_pc/instr_valid unchanged, rom_addr=0xBFC00000, fetch_count unchanged; release -> consumed one edge later.
REQ-032 redirect=1, redirect_pc=0xBFC00107 at cnt=2 -> next rom_addr 0xBFC00104, instr_valid stays 0, instr after 4 cycles from bytes 0x104..0x107.
REQ-033 redirect and consumption same edge (redirect_pc=0xBFC00040) -> fetch_count unchanged, next instr_pc=0xBFC00040.
REQ-034 RESET_PC=0xFFFFFFFC, stall=0 -> first instr_pc 0xFFFFFFFC, second fetch rom_addr 0x00000000..3.
REQ-035 rst pulsed (no clock edge) while in HOLD -> instr_valid=0, rom_addr=RESET_PC immediately.
